// File: rtl/red_accum.sv
// Multi-cycle reduction of the adder's RED-mode lane outputs: each {carry, nibble}
// lane value is added in turn into one zero-extended OUT_W-bit result.
module red_accum #(
  parameter int LANES  = 4,
  parameter int LANE_W = 4,
  parameter int OUT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [LANES*LANE_W-1:0]   lane_sum,
  input  logic [LANES-1:0]          lane_carry,
  output logic                      busy,
  output logic                      done,
  output logic [OUT_W-1:0]          result
);

  localparam int CNT_W = (LANES > 2) ? 2 : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [OUT_W-1:0]             acc_q, acc_d;
  logic [OUT_W-1:0]             result_q, result_d;
  logic [LANES-1:0][LANE_W:0]   buf_q, buf_d;

  logic [LANES-1:0][LANE_W:0]   capture;
  logic [OUT_W-1:0]             lane_ext;
  logic [OUT_W-1:0]             acc_sum;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      capture[i] = {lane_carry[i], lane_sum[i*LANE_W +: LANE_W]};
    end
  end

  assign lane_ext = {{(OUT_W-LANE_W-1){1'b0}}, buf_q[cnt_q]};
  assign acc_sum  = acc_q + lane_ext;

  // The final sum goes straight into result on the ACC->DONE edge, so result is
  // already valid during the single DONE cycle in which done is high.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    buf_d    = buf_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            buf_d   = capture;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACC;
          end else begin
            state_d = IDLE;
          end
        end
        ACC: begin
          if (!stall) begin
            acc_d = acc_sum;
            if (cnt_q == LAST_LANE) begin
              cnt_d    = '0;
              result_d = acc_sum;
              state_d  = DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      buf_q    <= buf_d;
    end
  end

  assign busy   = (state_q == ACC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_red_accum.sv
// Scoreboarded random/directed bench for red_accum: expected sums are queued at
// issue time and a negedge monitor pops one per done pulse.
module tb_red_accum;

  localparam int LANES = 4;

  logic        clk;
  logic        rstN;
  logic        start;
  logic        stall;
  logic        flush;
  logic [15:0] laneSum;
  logic [3:0]  laneCarry;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int expQ[$];
  int passed = 0;
  int total  = 0;
  int lastRes = 0;

  red_accum #(.LANES(LANES), .LANE_W(4), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rstN), .start(start), .stall(stall), .flush(flush),
    .lane_sum(laneSum), .lane_carry(laneCarry),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: sum of every lane's {carry, nibble} read as plain integers.
  function automatic int refSum(input logic [15:0] s, input logic [3:0] c);
    int t = 0;
    for (int i = 0; i < LANES; i++) begin
      t += int'((s >> (4*i)) & 16'hF) + (c[i] ? 16 : 0);
    end
    return t;
  endfunction

  always @(negedge clk) begin
    if (rstN && done) begin
      checkOutput("doneExpected", (expQ.size() > 0) ? 1 : 0, 1);
      if (expQ.size() > 0) checkOutput("result", result, expQ.pop_front());
      checkOutput("busyInDone", busy, 0);
    end
  end

  // Issue one reduction from a negedge; returns at the negedge of its done cycle.
  task automatic applyStimulus(input logic [15:0] s, input logic [3:0] c,
                               input int stallPct, input logic [31:0] stallMask,
                               input bit junkStart, input int expLat);
    int stalls = 0;
    int lat = 0;
    laneSum = s; laneCarry = c; start = 1'b1;
    expQ.push_back(refSum(s, c));
    lastRes = refSum(s, c);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start = 1'b0; stall = 1'b0;
      if (done) begin lat = cyc; break; end
      checkOutput("busyInAcc", busy, 1);
      if ((cyc < 32 && stallMask[cyc]) || $urandom_range(99) < stallPct) begin
        stall = 1'b1; stalls++;
      end
      if (junkStart && cyc == 2) begin
        start = 1'b1; laneSum = 16'($urandom); laneCarry = 4'($urandom);
      end
    end
    checkOutput("latency", lat, (expLat > 0) ? expLat : LANES + 1 + stalls);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("busyIdle", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstN = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
    laneSum = '0; laneCarry = '0;
    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetResult", result, 0);
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;
    idle(2);

    applyStimulus(16'h4321, 4'b0000, 0, 32'h0, 1'b0, 5);
    idle(2);
    checkOutput("resultHeld", result, 10);
    applyStimulus(16'hFFFF, 4'b1111, 0, 32'h0, 1'b0, 5);
    idle(1);
    applyStimulus(16'hFFFF, 4'b0101, 0, 32'h0, 1'b0, 5);
    idle(1);
    applyStimulus(16'h4321, 4'b0000, 0, 32'h1C, 1'b0, 8);
    idle(1);

    // Back-to-back: second start lands in the first op's DONE cycle.
    applyStimulus(16'hFFFF, 4'b1111, 0, 32'h0, 1'b0, 5);
    applyStimulus(16'h1234, 4'b1000, 0, 32'h0, 1'b1, 5);
    idle(1);
    applyStimulus(16'hFFFF, 4'b1111, 0, 32'h0, 1'b0, 5);
    idle(1);

    // Flush mid-reduction: no done, previous result kept.
    laneSum = 16'h2222; laneCarry = 4'b1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); flush = 1'b1; stall = 1'b1;
    @(negedge clk); flush = 1'b0; stall = 1'b0;
    checkOutput("flushBusy", busy, 0);
    checkOutput("flushResult", result, 124);
    idle(6);
    checkOutput("flushResultHeld", result, 124);
    applyStimulus(16'h1111, 4'b0000, 0, 32'h0, 1'b0, 5);
    idle(1);

    // Start together with flush captures nothing.
    laneSum = 16'h9999; laneCarry = 4'b1111; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    idle(7);
    checkOutput("startFlushResult", result, 4);

    // Asynchronous reset while the counter is at lane 2.
    laneSum = 16'h5555; laneCarry = 4'b0011; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("busyBeforeReset", busy, 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("asyncResetBusy", busy, 0);
    checkOutput("asyncResetDone", done, 0);
    checkOutput("asyncResetResult", result, 0);
    @(negedge clk); rstN = 1'b1;
    idle(3);
    checkOutput("postResetResult", result, 0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(16'($urandom), 4'($urandom), 30, 32'h0, bit'($urandom_range(1)), 0);
      idle($urandom_range(2));
    end

    idle(8);
    checkOutput("queueDrained", expQ.size(), 0);
    checkOutput("finalResult", result, lastRes);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/red_accum.md
Name: red_accum

Overview:
- Multi-cycle reduction unit that consumes the RED-mode output of the 16-bit ALU adder.
- Inputs from the adder: four nibble-lane sums (sum bus) and the per-lane carry-outs (single bus).
- Each lane value is 5 bits: {carry, nibble}. The unit adds all four lane values sequentially into one zero-extended 16-bit result.
- Sits in EX beside the adder. Handshakes with pipeline control through start/busy/done and honours stall and flush.

Parameters:
LANES, 4, number of nibble lanes reduced (valid range 2..4)
LANE_W, 4, bits per lane sum; each lane value is LANE_W+1 bits with the carry
OUT_W, 16, result width; lane values and the accumulator are zero-extended to this width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request: capture lane_sum/lane_carry and begin reduction
stall  input  1  pipeline stall; freezes state, counter, and accumulator
flush  input  1  abort any in-flight reduction
lane_sum  input  LANES*LANE_W  adder sum output in RED mode (lane i at bits [4i+3:4i])
lane_carry  input  LANES  adder per-lane carry-out (single bus); bit i belongs to lane i
busy  output  1  high while in CAPT or ACC
done  output  1  one-cycle pulse when result becomes valid
result  output  OUT_W  reduced sum; holds its value until the next completion

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst_n is asynchronous and active-low. Assertion immediately forces state=IDLE, busy=0, done=0, result=0, accumulator=0, lane counter=0, lane buffer=0.
  - Deassertion is synchronous to clk.
- States: IDLE, ACC, DONE.
- IDLE:
  - start=1 and flush=0 → capture lane buffer[i] = {lane_carry[i], lane_sum[4i+3:4i]}, clear accumulator, counter=0, go to ACC.
  - stall is ignored for capture; start is already qualified by control.
- ACC:
  - Each non-stalled cycle: accumulator += zero-extended buffer[counter]; counter++.
  - When counter reaches LANES-1 and that lane has been added, go to DONE.
  - stall=1 holds everything; no lane is skipped or double-added.
- DONE:
  - result <= accumulator; done=1 for exactly this cycle.
  - start=1 in DONE captures new operands and goes directly to ACC (back-to-back, no IDLE bubble). Otherwise go to IDLE.
- Latency: start accepted in cycle 0 → ACC during cycles 1..LANES → done and result valid in cycle LANES+1 (cycle 5 at default), absent stalls. Each stalled cycle adds exactly one cycle.
- busy=1 in ACC only. Per the port list it also covers CAPT, which is folded into the IDLE→ACC edge.
- busy=0 in IDLE and DONE, so start is never blocked in DONE.
- start while in ACC is ignored; operands are not re-captured. Control must hold start until busy=0.
- flush=1 in any state: next state IDLE, counter and accumulator cleared, done not asserted. result keeps its previous completed value.
- flush and start in the same cycle: flush wins and nothing is captured.
- flush and stall together: flush wins.
- Arithmetic and widths:
  - Max result at defaults is 4*31 = 124; no overflow or saturation logic.
  - The accumulator is OUT_W bits, and the upper bits are guaranteed zero at defaults.
- result changes only on the DONE transition or reset. It is registered and not combinational from inputs.

Test Plan:
- Reset mid-ACC: assert rst_n=0 while counter=2 → busy, done, and result all 0 immediately, without waiting for clk; after release, state is IDLE.
- Basic reduction: lane_sum=16'h4321, lane_carry=4'b0000, start for 1 cycle → done pulses in cycle 5 with result=16'd10; busy high cycles 1-4.
- Carries included: lane_sum=16'hFFFF, lane_carry=4'b1111 → result=16'd124. Then lane_carry=4'b0101 → result=16'd92.
- Stall: same stimulus as the basic case with stall high for 3 cycles during ACC → done arrives in cycle 8, result=10. Done is a single pulse.
- Flush: flush at cycle 2, with a previous result=124 → no done; result stays 124; state IDLE. A following start with 16'h1111/4'b0000 → result=4.
- Back-to-back and collisions:
  - start asserted in the DONE cycle → second result appears 5 cycles after the first done.
  - start while busy → ignored, and the result reflects the first operands only.
  - start with flush in the same cycle → no capture.
